// File: rtl/cpu_pkg.sv
// Shared CPU constants, register address type and named register indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int WORD_W  = 16;
  localparam int NUM_GPR = 8;
  localparam int GPR_AW  = $clog2(NUM_GPR);

  typedef logic [GPR_AW-1:0] reg_addr_t;

  // Architectural names for the default eight-register file
  typedef enum logic [GPR_AW-1:0] {
    R_A  = 3'd0,
    R_B  = 3'd1,
    R_C  = 3'd2,
    R_D  = 3'd3,
    R_E  = 3'd4,
    R_F  = 3'd5,
    R_SP = 3'd6,
    R_PC = 3'd7
  } reg_idx_e;

endpackage

// File: rtl/reg_read_port.sv
// One read port: negedge capture latch feeding a tristate bus driver.
// Latency: captures on negedge, bus enable is purely combinational.
// Backpressure: none; the latch captures every negedge regardless of rd_en.
module reg_read_port #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd_val,
  input  logic             rd_en,
  output wire  [WIDTH-1:0] bus
);

  logic [WIDTH-1:0] latch_d;
  logic [WIDTH-1:0] latch_q;

  // Next capture value is the already-decoded register contents
  always_comb begin
    latch_d = rd_val;
  end

  // Capture on the falling edge so the bus is settled before the next rising edge
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign bus = rd_en ? latch_q : {WIDTH{1'bz}};

endmodule

// File: rtl/reg_file.sv
// Multi-register file: one write port, one increment port, NREAD tristate read buses.
// Latency: write/increment at posedge, visible on a bus after the following negedge.
// Backpressure: none; every enabled operation completes in the cycle it is presented.
module reg_file
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = NUM_GPR,
  parameter int AW       = GPR_AW,
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   inc_en,
  input  logic [AW-1:0]          inc_addr,
  input  logic [WIDTH-1:0]       inc_step,
  input  logic [NREAD*AW-1:0]    rd_addr,
  input  logic [NREAD-1:0]       rd_en,
  output wire  [NREAD*WIDTH-1:0] rd_bus,
  output logic                   inc_carry
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q;
  logic             carry_d;
  logic [WIDTH-1:0] inc_cur;
  logic [WIDTH:0]   inc_sum;
  logic             wr_ok;
  logic             inc_ok;

  // An address names real storage only below DEPTH, and never register 0 when it is hard-wired
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (a == AW'(k)) ok = 1'b1;
    end
    if (ZERO_REG != 0 && a == '0) ok = 1'b0;
    return ok;
  endfunction

  // Fetch the increment operand without indexing past the end of the array
  always_comb begin
    inc_cur = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (inc_addr == AW'(k)) inc_cur = regs_q[k];
    end
  end

  assign inc_sum = {1'b0, inc_cur} + {1'b0, inc_step};
  assign wr_ok   = wr_en && addr_ok(wr_addr);
  assign inc_ok  = inc_en && addr_ok(inc_addr);

  // Apply increment then write, so a same-address write overrides the increment
  always_comb begin
    regs_d  = regs_q;
    carry_d = inc_ok ? inc_sum[WIDTH] : carry_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (inc_ok && inc_addr == AW'(k)) regs_d[k] = inc_sum[WIDTH-1:0];
      if (wr_ok && wr_addr == AW'(k))   regs_d[k] = wr_data;
    end
  end

  // Register storage and carry flag, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
    end
  end

  assign inc_carry = carry_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] val;

    assign addr = rd_addr[i*AW +: AW];

    // Decode this port's register; unmapped or hard-wired-zero addresses read 0
    always_comb begin
      val = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (addr_ok(addr) && addr == AW'(k)) val = regs_q[k];
      end
    end

    reg_read_port #(.WIDTH(WIDTH)) u_port (
      .clk    (clk),
      .reset  (reset),
      .rd_val (val),
      .rd_en  (rd_en[i]),
      .bus    (rd_bus[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
  import cpu_pkg::*;

  localparam int W    = WORD_W;
  localparam int NR   = 3;
  localparam int AW   = GPR_AW;
  localparam int NCFG = 3;
  localparam int CFG_DEPTH [NCFG] = '{8, 6, 8};
  localparam int CFG_ZERO  [NCFG] = '{0, 0, 1};
  // Undriven buses are pulled up, so high-Z reads back as all ones
  localparam logic [W-1:0] ZBUS = '1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  reg_addr_t         wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic              inc_en = 1'b0;
  reg_addr_t         inc_addr = '0;
  logic [W-1:0]      inc_step = '0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR-1:0]     rd_en = '0;

  wire [NR*W-1:0] bus_m, bus_d6, bus_z;
  wire            c_m, c_d6, c_z;
  pullup (bus_m);
  pullup (bus_d6);
  pullup (bus_z);

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state per configuration
  int unsigned m_reg   [NCFG][16];
  int unsigned m_latch [NCFG][NR];
  int unsigned m_carry [NCFG];

  always #5 clk = ~clk;

  reg_file u_main (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inc_en(inc_en), .inc_addr(inc_addr), .inc_step(inc_step), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_bus(bus_m), .inc_carry(c_m));

  reg_file #(.DEPTH(6), .AW(3)) u_d6 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inc_en(inc_en), .inc_addr(inc_addr), .inc_step(inc_step), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_bus(bus_d6), .inc_carry(c_d6));

  reg_file #(.ZERO_REG(1)) u_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inc_en(inc_en), .inc_addr(inc_addr), .inc_step(inc_step), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_bus(bus_z), .inc_carry(c_z));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bus_of(input int c, input int i);
    logic [NR*W-1:0] v;
    case (c)
      0:       v = bus_m;
      1:       v = bus_d6;
      default: v = bus_z;
    endcase
    return v[i*W +: W];
  endfunction

  function automatic logic carry_of(input int c);
    case (c)
      0:       return c_m;
      1:       return c_d6;
      default: return c_z;
    endcase
  endfunction

  function automatic bit m_ok(input int c, input int a);
    return (a < CFG_DEPTH[c]) && !(CFG_ZERO[c] != 0 && a == 0);
  endfunction

  function automatic int rda(input int i);
    logic [NR*AW-1:0] v;
    v = rd_addr;
    return int'(v[i*AW +: AW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      for (int k = 0; k < 16; k++) m_reg[c][k] = 0;
      for (int i = 0; i < NR; i++) m_latch[c][i] = 0;
      m_carry[c] = 0;
    end
  endtask

  task automatic model_posedge();
    for (int c = 0; c < NCFG; c++) begin
      if (inc_en && m_ok(c, int'(inc_addr))) begin
        int unsigned s;
        s = m_reg[c][inc_addr] + int'(inc_step);
        m_carry[c] = s >> W;
        m_reg[c][inc_addr] = s % 65536;
      end
      if (wr_en && m_ok(c, int'(wr_addr))) m_reg[c][wr_addr] = int'(wr_data);
    end
  endtask

  task automatic model_negedge();
    for (int c = 0; c < NCFG; c++)
      for (int i = 0; i < NR; i++)
        m_latch[c][i] = m_ok(c, rda(i)) ? m_reg[c][rda(i)] : 0;
  endtask

  task automatic check_all(input string where);
    for (int c = 0; c < NCFG; c++) begin
      for (int i = 0; i < NR; i++)
        chk($sformatf("%s_c%0d_bus%0d", where, c, i), 32'(bus_of(c, i)),
            rd_en[i] ? m_latch[c][i] : 32'(ZBUS));
      chk($sformatf("%s_c%0d_carry", where, c), 32'(carry_of(c)), m_carry[c]);
    end
  endtask

  // One clock: update at posedge, capture at negedge, check just after
  task automatic cycle(input string where);
    @(posedge clk);
    model_posedge();
    @(negedge clk);
    model_negedge();
    #1;
    check_all(where);
  endtask

  task automatic set(input logic we, input int wa, input logic [W-1:0] wd,
                     input logic ie, input int ia, input logic [W-1:0] st,
                     input int r0, input int r1, input int r2, input logic [NR-1:0] re);
    wr_en = we; wr_addr = reg_addr_t'(wa); wr_data = wd;
    inc_en = ie; inc_addr = reg_addr_t'(ia); inc_step = st;
    rd_addr = {AW'(r2), AW'(r1), AW'(r0)};
    rd_en = re;
  endtask

  task automatic do_reset(input string where);
    rd_en = '1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(where);
    for (int i = 0; i < NR; i++) chk($sformatf("%s_main_bus%0d", where, i), 32'(bus_of(0, i)), 32'h0);
    chk({where, "_main_carry"}, 32'(c_m), 32'h0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    do_reset("init_rst");

    // Write then read on port 0; ports 1 and 2 disabled
    set(1, 2, 16'hBEEF, 0, 0, 0, 2, 0, 0, 3'b001);
    cycle("wr_read");
    chk("wr_read_bus0", 32'(bus_of(0, 0)), 32'hBEEF);
    chk("wr_read_bus1_z", 32'(bus_of(0, 1)), 32'(ZBUS));

    // Increment wraps 0xFFFF -> 0 with carry
    set(1, 5, 16'hFFFF, 0, 0, 0, 5, 0, 0, 3'b001);
    cycle("pre_inc");
    set(0, 0, 0, 1, 5, 16'h0001, 5, 0, 0, 3'b001);
    cycle("inc_wrap");
    chk("inc_wrap_val", 32'(bus_of(0, 0)), 32'h0000);
    chk("inc_wrap_carry", 32'(c_m), 32'h1);

    // Plain write must leave carry untouched
    set(1, 3, 16'h0010, 0, 0, 0, 3, 0, 0, 3'b001);
    cycle("carry_hold");
    chk("carry_hold", 32'(c_m), 32'h1);

    // Same-address collision: write wins, carry taken from discarded sum
    set(1, 3, 16'h1234, 1, 3, 16'h0001, 3, 0, 0, 3'b001);
    cycle("collide");
    chk("collide_val", 32'(bus_of(0, 0)), 32'h1234);
    chk("collide_carry", 32'(c_m), 32'h0);

    // Decrement from zero
    set(0, 0, 0, 1, 5, 16'hFFFF, 5, 0, 0, 3'b001);
    cycle("dec");
    chk("dec_val", 32'(bus_of(0, 0)), 32'hFFFF);
    chk("dec_carry", 32'(c_m), 32'h0);

    // Different addresses update together
    set(1, 3, 16'h3333, 1, 4, 16'h0002, 3, 4, 0, 3'b011);
    cycle("dual");
    chk("dual_wr", 32'(bus_of(0, 0)), 32'h3333);
    chk("dual_inc", 32'(bus_of(0, 1)), 32'h0002);

    // Out-of-range address on the six-register instance
    set(1, 7, 16'h7777, 0, 0, 0, 7, 0, 0, 3'b001);
    cycle("oob");
    chk("oob_d6_read", 32'(bus_of(1, 0)), 32'h0);
    chk("oob_main_read", 32'(bus_of(0, 0)), 32'h7777);

    // Hard-wired zero register
    set(1, 0, 16'hAAAA, 0, 0, 0, 0, 0, 0, 3'b001);
    cycle("zreg");
    chk("zreg_read", 32'(bus_of(2, 0)), 32'h0);
    chk("zreg_main", 32'(bus_of(0, 0)), 32'hAAAA);

    // All ports read one register; enables toggle combinationally mid-cycle
    set(1, 1, 16'h5A5A, 0, 0, 0, 1, 1, 1, 3'b111);
    cycle("multi");
    for (int i = 0; i < NR; i++) chk($sformatf("multi_bus%0d", i), 32'(bus_of(0, i)), 32'h5A5A);
    rd_en = 3'b000;
    #1;
    for (int i = 0; i < NR; i++) chk($sformatf("multi_off%0d", i), 32'(bus_of(0, i)), 32'(ZBUS));
    rd_en = 3'b101;
    #1;
    chk("multi_on0", 32'(bus_of(0, 0)), 32'h5A5A);
    chk("multi_off1", 32'(bus_of(0, 1)), 32'(ZBUS));
    chk("multi_on2", 32'(bus_of(0, 2)), 32'h5A5A);
    check_all("multi_toggle");

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] st;
      case ($urandom_range(0, 3))
        0:       st = 16'h0001;
        1:       st = 16'hFFFF;
        default: st = W'($urandom);
      endcase
      set(1'($urandom), int'($urandom_range(0, 7)), W'($urandom),
          1'($urandom), int'($urandom_range(0, 7)), st,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), NR'($urandom));
      cycle("rand");
      if ($urandom_range(0, 49) == 0) do_reset("rand_rst");
    end

    // Reset with populated registers, then confirm storage cleared
    do_reset("final_rst");
    set(0, 0, 0, 0, 0, 0, 5, 6, 7, 3'b111);
    cycle("post_rst");
    for (int i = 0; i < NR; i++) chk($sformatf("post_rst_bus%0d", i), 32'(bus_of(0, i)), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
